// File: rtl/cf_spi_slave.sv
// SPI responder: host bus oversampled in the clk domain, MSB-first shifting,
// with RX and TX byte FIFOs sharing the master's bus-side flag interface.
module cf_spi_slave #(
    parameter int         FAW  = 4,
    parameter logic [7:0] FILL = 8'hFF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           CPOL,
    input  logic           CPHA,
    input  logic           wr,
    input  logic [7:0]     datai,
    input  logic           rd,
    output logic [7:0]     datao,
    input  logic           rx_en,
    input  logic           rx_flush,
    input  logic [FAW-1:0] rx_threshold,
    output logic           rx_empty,
    output logic           rx_full,
    output logic [FAW:0]   rx_level,
    output logic           rx_level_above,
    input  logic           tx_flush,
    input  logic [FAW-1:0] tx_threshold,
    output logic           tx_empty,
    output logic           tx_full,
    output logic [FAW:0]   tx_level,
    output logic           tx_level_below,
    output logic           busy,
    output logic           done,
    output logic           rx_overrun,
    output logic           tx_underrun,
    input  logic           sclk,
    input  logic           csb,
    input  logic           mosi,
    output logic           miso,
    output logic           miso_oe
);
    localparam int           DEPTH    = 1 << FAW;
    localparam logic [FAW:0] FULL_LVL = (FAW + 1)'(DEPTH);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEL = 1'b1} state_t;
    state_t state_r, state_n;

    logic           sclk_s1_r, sclk_s2_r, sclk_d_r;
    logic           csb_s1_r, csb_s2_r, csb_d_r;
    logic           mosi_s1_r, mosi_s2_r;
    logic [1:0]     sync_ok_r;
    logic           armed_r;
    logic [2:0]     bit_cnt_r;
    logic [6:0]     rx_shift_r, tx_shift_r;
    logic           miso_r, miso_oe_r, done_r, rx_overrun_r, tx_underrun_r;

    logic [7:0]     rx_mem_r [DEPTH];
    logic [7:0]     tx_mem_r [DEPTH];
    logic [FAW-1:0] rx_wptr_r, rx_rptr_r, tx_wptr_r, tx_rptr_r;
    logic [FAW:0]   rx_level_r, tx_level_r;

    logic sclk_edge_s, lead_s, trail_s, sample_edge_s, shift_edge_s;
    logic csb_fall_s, csb_rise_s, enter_s, in_sel_s, sample_s, byte_done_s;
    logic load_s, shift_out_s, rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;
    logic [7:0] rx_byte_s, load_byte_s;

    // Two-stage synchronizers plus one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1_r <= CPOL;
            sclk_s2_r <= CPOL;
            sclk_d_r  <= CPOL;
            csb_s1_r  <= 1'b1;
            csb_s2_r  <= 1'b1;
            csb_d_r   <= 1'b1;
            mosi_s1_r <= 1'b0;
            mosi_s2_r <= 1'b0;
            sync_ok_r <= 2'b00;
            armed_r   <= 1'b0;
        end else begin
            sclk_s1_r <= sclk;
            sclk_s2_r <= sclk_s1_r;
            sclk_d_r  <= sclk_s2_r;
            csb_s1_r  <= csb;
            csb_s2_r  <= csb_s1_r;
            csb_d_r   <= csb_s2_r;
            mosi_s1_r <= mosi;
            mosi_s2_r <= mosi_s1_r;
            sync_ok_r <= {sync_ok_r[0], 1'b1};
            // A select seen low straight out of reset must not arm; require the real pin high first
            if (sync_ok_r[1] && csb_s2_r) begin
                armed_r <= 1'b1;
            end
        end
    end

    assign sclk_edge_s   = sclk_s2_r ^ sclk_d_r;
    assign lead_s        = sclk_edge_s & (sclk_s2_r ^ CPOL);
    assign trail_s       = sclk_edge_s & ~(sclk_s2_r ^ CPOL);
    assign sample_edge_s = CPHA ? trail_s : lead_s;
    assign shift_edge_s  = CPHA ? lead_s : trail_s;
    assign csb_fall_s    = armed_r & csb_d_r & ~csb_s2_r;
    assign csb_rise_s    = ~csb_d_r & csb_s2_r;

    // Select state next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable && csb_fall_s) state_n = ST_SEL;
                else                      state_n = ST_IDLE;
            end
            ST_SEL: begin
                if (!enable || csb_rise_s) state_n = ST_IDLE;
                else                       state_n = ST_SEL;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign enter_s     = (state_r == ST_IDLE) && (state_n == ST_SEL);
    assign in_sel_s    = (state_r == ST_SEL) && (state_n == ST_SEL);
    assign sample_s    = in_sel_s & sample_edge_s;
    assign byte_done_s = sample_s & (bit_cnt_r == 3'd7);
    // bit_cnt is 0 only at a byte boundary, so a shift edge there starts a new byte
    assign load_s      = (in_sel_s & shift_edge_s & (bit_cnt_r == 3'd0)) | (enter_s & ~CPHA);
    assign shift_out_s = in_sel_s & shift_edge_s & (bit_cnt_r != 3'd0);
    assign rx_byte_s   = {rx_shift_r, mosi_s2_r};
    assign load_byte_s = tx_empty ? FILL : tx_mem_r[tx_rptr_r];
    assign tx_pop_s    = load_s & ~tx_empty;
    assign tx_push_s   = wr & ~tx_full;
    assign rx_push_s   = byte_done_s & rx_en & ~rx_full;
    assign rx_pop_s    = rd & ~rx_empty;

    // Select state, bit counter, shift registers and event pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= 3'd0;
            rx_shift_r    <= 7'd0;
            tx_shift_r    <= 7'd0;
            miso_r        <= 1'b0;
            miso_oe_r     <= 1'b0;
            done_r        <= 1'b0;
            rx_overrun_r  <= 1'b0;
            tx_underrun_r <= 1'b0;
        end else begin
            state_r       <= state_n;
            done_r        <= byte_done_s;
            rx_overrun_r  <= byte_done_s & rx_en & rx_full;
            tx_underrun_r <= load_s & tx_empty;
            if (enter_s) begin
                miso_oe_r <= 1'b1;
                bit_cnt_r <= 3'd0;
            end else if (state_n == ST_IDLE) begin
                miso_oe_r <= 1'b0;
                bit_cnt_r <= 3'd0;
            end else if (sample_s) begin
                bit_cnt_r  <= bit_cnt_r + 3'd1;
                rx_shift_r <= rx_byte_s[6:0];
            end
            if (load_s) begin
                miso_r     <= load_byte_s[7];
                tx_shift_r <= load_byte_s[6:0];
            end else if (shift_out_s) begin
                miso_r     <= tx_shift_r[6];
                tx_shift_r <= {tx_shift_r[5:0], 1'b0};
            end
        end
    end

    // RX FIFO pointers and occupancy; flush wins over push/pop
    always_ff @(posedge clk) begin
        if (rst || rx_flush) begin
            rx_wptr_r  <= {FAW{1'b0}};
            rx_rptr_r  <= {FAW{1'b0}};
            rx_level_r <= {(FAW + 1){1'b0}};
        end else begin
            if (rx_push_s) rx_wptr_r <= rx_wptr_r + FAW'(1);
            if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + FAW'(1);
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_level_r <= rx_level_r + (FAW + 1)'(1);
                2'b01:   rx_level_r <= rx_level_r - (FAW + 1)'(1);
                default: rx_level_r <= rx_level_r;
            endcase
        end
    end

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (!rst && !rx_flush && rx_push_s) rx_mem_r[rx_wptr_r] <= rx_byte_s;
    end

    // TX FIFO pointers and occupancy; flush wins over push/pop
    always_ff @(posedge clk) begin
        if (rst || tx_flush) begin
            tx_wptr_r  <= {FAW{1'b0}};
            tx_rptr_r  <= {FAW{1'b0}};
            tx_level_r <= {(FAW + 1){1'b0}};
        end else begin
            if (tx_push_s) tx_wptr_r <= tx_wptr_r + FAW'(1);
            if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + FAW'(1);
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_level_r <= tx_level_r + (FAW + 1)'(1);
                2'b01:   tx_level_r <= tx_level_r - (FAW + 1)'(1);
                default: tx_level_r <= tx_level_r;
            endcase
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (!rst && !tx_flush && tx_push_s) tx_mem_r[tx_wptr_r] <= datai;
    end

    assign datao          = rx_mem_r[rx_rptr_r];
    assign rx_level       = rx_level_r;
    assign rx_empty       = (rx_level_r == {(FAW + 1){1'b0}});
    assign rx_full        = (rx_level_r == FULL_LVL);
    assign rx_level_above = (rx_level_r > {1'b0, rx_threshold});
    assign tx_level       = tx_level_r;
    assign tx_empty       = (tx_level_r == {(FAW + 1){1'b0}});
    assign tx_full        = (tx_level_r == FULL_LVL);
    assign tx_level_below = (tx_level_r < {1'b0, tx_threshold});
    assign busy           = (state_r == ST_SEL);
    assign done           = done_r;
    assign rx_overrun     = rx_overrun_r;
    assign tx_underrun    = tx_underrun_r;
    assign miso           = miso_r;
    assign miso_oe        = miso_oe_r;
endmodule

// File: doc/cf_spi_slave.md
Name: cf_spi_slave

Overview:
SPI responder (slave) for the SoC peripheral set. It is the opposite end of the CF SPI master: an external host drives sclk, csb and mosi, and this block returns data on miso. Bytes received from the host go into an RX FIFO, and bytes to be sent come from a TX FIFO. The bus-side FIFO and flag interface matches the master's, so the register-wrapper logic can be shared. All bus inputs are oversampled in the clk domain; there is no sclk clock domain.

Parameters:
FAW, 4, FIFO address width; each FIFO is 2^FAW entries deep.
FILL, 8'hFF, byte shifted out on miso when the TX FIFO is empty at byte load.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
enable  input  1  0 = ignore the bus; miso_oe held 0
CPOL  input  1  sclk idle level
CPHA  input  1  0 = sample on leading edge, 1 = sample on trailing edge
wr  input  1  push datai into the TX FIFO
datai  input  8  TX write data
rd  input  1  pop the RX FIFO
datao  output  8  RX FIFO head
rx_en  input  1  allow received bytes into the RX FIFO
rx_flush  input  1  empty the RX FIFO
rx_threshold  input  FAW  RX level threshold
rx_empty, rx_full  output  1  RX FIFO status
rx_level  output  FAW+1  RX occupancy, 0..2^FAW
rx_level_above  output  1  rx_level > rx_threshold
tx_flush  input  1  empty the TX FIFO
tx_threshold  input  FAW  TX level threshold
tx_empty, tx_full  output  1  TX FIFO status
tx_level  output  FAW+1  TX occupancy
tx_level_below  output  1  tx_level < tx_threshold
busy  output  1  slave currently selected (synchronized csb low and enable high)
done  output  1  one-cycle pulse per completed byte
rx_overrun  output  1  one-cycle pulse when a byte is dropped because the RX FIFO is full
tx_underrun  output  1  one-cycle pulse when FILL is loaded because the TX FIFO is empty
sclk  input  1  host clock
csb  input  1  chip select, active low
mosi  input  1  host data in
miso  output  1  data to host
miso_oe  output  1  pad output enable for miso

Behaviour:
- Reset (rst high at a clk edge) gives:
  - both FIFOs empty, levels 0;
  - busy=0, done=0, rx_overrun=0, tx_underrun=0;
  - miso=0, miso_oe=0;
  - bit counter 0;
  - synchronizers loaded with idle values (csb=1, sclk=CPOL).
- Reset mid-frame aborts the frame. The block re-arms only on the next csb falling edge.
- Synchronization: sclk, csb and mosi each pass through a 2-FF synchronizer. Edges are detected on the synchronized sclk, so pin-to-action latency is 3 clk cycles.
- Timing requirement: f_sclk <= f_clk/8.
- Edge naming: the leading edge is the sclk transition away from CPOL; the trailing edge is the transition back. CPHA selects the edges:
  - CPHA=0: sample on leading, shift on trailing.
  - CPHA=1: shift on leading, sample on trailing.
- Slave states: IDLE, SEL.
  - IDLE -> SEL on a synchronized csb falling edge while enable=1. At this point bit_cnt=0 and miso_oe=1.
  - SEL -> IDLE on csb rising edge, or on enable falling.
- Byte load: the TX FIFO is popped (1-cycle rd) when a byte is loaded. A byte loads:
  - CPHA=0: at SEL entry, and on the shift edge following each completed byte. The MSB is on miso before the first sample edge.
  - CPHA=1: at the first shift edge of each byte. The MSB appears on that edge.
- Empty TX FIFO at load: the FILL byte is loaded and tx_underrun pulses.
- Bit order: MSB first. miso changes only on shift edges (or on a CPHA=0 load).
- Sampling: each sample edge shifts mosi into rx_shift and increments the 3-bit bit_cnt.
- Byte completion: on the 8th sample edge, done pulses.
  - If rx_en=1 and the RX FIFO is not full, the byte is pushed.
  - If rx_en=1 and the RX FIFO is full, the byte is dropped and rx_overrun pulses.
  - If rx_en=0, the byte is discarded silently.
- csb rises mid-byte: the partial RX byte is discarded (no push, no done), bit_cnt returns to 0, and miso_oe=0 on the same cycle the synchronized csb rises. A TX byte that was loaded but not fully shifted is lost, not re-queued.
- sclk edges while in IDLE are ignored.
- Changing CPOL/CPHA while busy=1 is undefined. Firmware changes mode only when the block is idle.
- FIFOs:
  - Same-cycle push and pop are both honoured; level is unchanged.
  - Push when full is ignored; pop when empty is ignored and datao holds.
  - A flush overrides a same-cycle push or pop on that FIFO; the level becomes 0 the next cycle.
  - datao shows the head combinationally from the FIFO storage.
  - Levels saturate at 2^FAW, and the pointers wrap modulo 2^FAW.

Test Plan:
- Mode 0 (CPOL=0, CPHA=0), TX FIFO preloaded with A5 and 3C, host sends 0x81, 0x7E in one csb-low frame: host reads A5 then 3C; RX FIFO holds 81 then 7E; done pulses twice; rx_level=2.
- Modes 1, 2 and 3 each with TX=C3 and host sending 0x5A: host receives C3 and RX captures 5A in every mode. Check miso changes only on the shift edges.
- TX FIFO empty, host clocks 2 bytes: miso carries FF, FF; tx_underrun pulses twice.
- RX FIFO full (16 entries, FAW=4), host sends 0x11: FIFO contents unchanged; rx_overrun pulses once; rx_full stays 1.
- csb rises after 5 bits: no push, no done; the next frame with byte 0x99 is captured correctly as 99.
- rst asserted mid-byte with TX level 3: all levels 0, miso_oe=0, busy=0; continued sclk edges with csb still low cause no activity until csb toggles.
